store_size_unit: RTL and testbench

Sequencer that executes the store side of the load/store size path: `sw` (word), `sh` (halfword) and `sb` (byte). It sits between the multicycle control unit and data memory, opposite the load-size extractor. Word stores are written directly. Halfword and byte stores perform a read-modify-write, so bytes not covered by the store keep their values. Placement follows the same convention as the load path: the halfword or byte always occupies the low bits of the memory word.

---
 rtl/store_size_unit_pkg.sv | 22 ++
 rtl/store_size_unit_if.sv | 26 ++
 rtl/store_size_unit_merge.sv | 22 ++
 rtl/store_size_unit.sv | 94 +++++++++
 tb/tb_store_size_unit.sv | 206 ++++++++++++++++++++
 5 files changed

// File: rtl/store_size_unit_pkg.sv
// Shared size codes and FSM encoding for the store-size sequencer.
// The load-size extractor decodes the same size codes.
package ss_pkg;

    localparam logic [1:0] SS_WORD = 2'b00;
    localparam logic [1:0] SS_HALF = 2'b10;
    localparam logic [1:0] SS_BYTE = 2'b01;
    localparam logic [1:0] SS_RSVD = 2'b11;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } ss_state_t;

    // Sub-word stores must fetch the surrounding word before writing it back.
    function automatic logic ss_needs_rmw(input logic [1:0] size);
        return (size == SS_HALF) || (size == SS_BYTE);
    endfunction

endpackage

// File: rtl/store_size_unit_if.sv
// Request and data-memory bundle between the control unit, the store-size
// sequencer and data memory. master = control/memory side, slave = the sequencer.
interface store_size_if;

    logic        start;
    logic [1:0]  SScontroler;
    logic [31:0] addr;
    logic [31:0] B_out;
    logic [31:0] mem_rd_data;
    logic [31:0] mem_addr;
    logic        mem_wr;
    logic [31:0] mem_wr_data;
    logic        busy;
    logic        done;

    modport master (
        output start, SScontroler, addr, B_out, mem_rd_data,
        input  mem_addr, mem_wr, mem_wr_data, busy, done
    );

    modport slave (
        input  start, SScontroler, addr, B_out, mem_rd_data,
        output mem_addr, mem_wr, mem_wr_data, busy, done
    );

endinterface

// File: rtl/store_size_unit_merge.sv
// Merge store data into the fetched memory word; sub-words sit in the low bits.
// Latency: combinational.
// Backpressure: none, pure function of its inputs.
module ss_merge
    import ss_pkg::*;
(
    input  logic [1:0]  size,
    input  logic [31:0] mem_word,
    input  logic [31:0] store_data,
    output logic [31:0] merged
);

    always_comb begin
        merged = store_data;
        unique case (size)
            SS_HALF: merged = {mem_word[31:16], store_data[15:0]};
            SS_BYTE: merged = {mem_word[31:8],  store_data[7:0]};
            default: merged = store_data;
        endcase
    end

endmodule

// File: rtl/store_size_unit.sv
// Store-size sequencer: direct word writes, read-modify-write for half/byte.
// Latency: word write in cycle 1 / done cycle 2; sub-word write cycle MEM_LAT+2 / done MEM_LAT+3.
// Backpressure: none; start is only sampled in IDLE and is dropped otherwise.
module store_size_unit
    import ss_pkg::*;
#(
    parameter int MEM_LAT = 1
) (
    input  logic         clk,
    input  logic         reset,
    store_size_if.slave  bus
);

    localparam logic [2:0] READ_LAST = 3'(MEM_LAT);

    ss_state_t   state_q, state_d;
    logic [2:0]  cnt_q,   cnt_d;
    logic [1:0]  size_q,  size_d;
    logic [31:0] addr_q,  addr_d;
    logic [31:0] data_q,  data_d;
    logic [31:0] rd_q,    rd_d;
    logic [31:0] merged;

    ss_merge u_merge (
        .size       (size_q),
        .mem_word   (rd_q),
        .store_data (data_q),
        .merged     (merged)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            size_q  <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            rd_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            size_q  <= size_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            rd_q    <= rd_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        size_d  = size_q;
        addr_d  = addr_q;
        data_d  = data_q;
        rd_d    = rd_q;

        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    size_d = bus.SScontroler;
                    addr_d = bus.addr;
                    data_d = bus.B_out;
                    cnt_d  = '0;
                    if (bus.SScontroler == SS_WORD) begin
                        state_d = WRITE;
                    end else if (ss_needs_rmw(bus.SScontroler)) begin
                        state_d = READ;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            READ: begin
                // Counter reaches MEM_LAT on the last READ cycle; read data is valid by then.
                if (cnt_q == READ_LAST) begin
                    rd_d    = bus.mem_rd_data;
                    state_d = WRITE;
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end
            WRITE:   state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign bus.busy        = (state_q != IDLE);
    assign bus.done        = (state_q == DONE);
    assign bus.mem_wr      = (state_q == WRITE);
    assign bus.mem_addr    = ((state_q == READ) || (state_q == WRITE)) ? addr_q : 32'h0;
    assign bus.mem_wr_data = (state_q == WRITE) ? merged : 32'h0;

endmodule

// File: tb/tb_store_size_unit.sv
// Directed bench for store_size_unit: one instance with MEM_LAT=1, one with MEM_LAT=3,
// each backed by a small registered-read memory model.
module tb_store_size_unit;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    store_size_if a ();
    store_size_if b ();

    store_size_unit #(.MEM_LAT(1)) u1 (.clk(clk), .reset(reset), .bus(a.slave));
    store_size_unit #(.MEM_LAT(3)) u3 (.clk(clk), .reset(reset), .bus(b.slave));

    logic [31:0] mem1 [0:255];
    logic [31:0] mem3 [0:255];
    logic [31:0] p1, p3_0, p3_1, p3_2;
    int          wr1 = 0, wr3 = 0;
    logic        pl_en = 1'b0, pl_sel = 1'b0;
    logic [7:0]  pl_addr = '0;
    logic [31:0] pl_dat = '0;

    always @(posedge clk) begin
        if (pl_en && !pl_sel) mem1[pl_addr] <= pl_dat;
        else if (a.mem_wr) begin
            mem1[a.mem_addr[7:0]] <= a.mem_wr_data;
            wr1 <= wr1 + 1;
        end
        p1 <= mem1[a.mem_addr[7:0]];
    end

    always @(posedge clk) begin
        if (pl_en && pl_sel) mem3[pl_addr] <= pl_dat;
        else if (b.mem_wr) begin
            mem3[b.mem_addr[7:0]] <= b.mem_wr_data;
            wr3 <= wr3 + 1;
        end
        p3_0 <= mem3[b.mem_addr[7:0]];
        p3_1 <= p3_0;
        p3_2 <= p3_1;
    end

    assign a.mem_rd_data = p1;
    assign b.mem_rd_data = p3_2;

    int vectors = 0;
    int miscompares = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic preload(input logic sel, input logic [7:0] ad, input logic [31:0] d);
        pl_en = 1'b1; pl_sel = sel; pl_addr = ad; pl_dat = d;
        tick();
        pl_en = 1'b0;
    endtask

    initial begin
        int w0;
        bit seen;
        for (int i = 0; i < 256; i++) begin
            mem1[i] = '0;
            mem3[i] = '0;
        end
        a.start = 0; a.SScontroler = 2'b00; a.addr = '0; a.B_out = '0;
        b.start = 0; b.SScontroler = 2'b00; b.addr = '0; b.B_out = '0;
        tick(); tick();
        chk("rst_busy",  {31'b0, a.busy},   32'h0);
        chk("rst_done",  {31'b0, a.done},   32'h0);
        chk("rst_wr",    {31'b0, a.mem_wr}, 32'h0);
        chk("rst_addr",  a.mem_addr,        32'h0);
        chk("rst_wdata", a.mem_wr_data,     32'h0);
        reset = 0;
        preload(1'b0, 8'h10, 32'h11223344);
        preload(1'b0, 8'h20, 32'h55667788);
        preload(1'b1, 8'h08, 32'hCAFEF00D);

        // Word store
        w0 = wr1;
        a.start = 1; a.SScontroler = 2'b00; a.addr = 32'h40; a.B_out = 32'hDEADBEEF;
        tick(); a.start = 0;
        chk("w_c1_wr",    {31'b0, a.mem_wr}, 32'h1);
        chk("w_c1_addr",  a.mem_addr,        32'h40);
        chk("w_c1_data",  a.mem_wr_data,     32'hDEADBEEF);
        chk("w_c1_done",  {31'b0, a.done},   32'h0);
        chk("w_c1_busy",  {31'b0, a.busy},   32'h1);
        tick();
        chk("w_c2_done",  {31'b0, a.done},   32'h1);
        chk("w_c2_wr",    {31'b0, a.mem_wr}, 32'h0);
        chk("w_c2_busy",  {31'b0, a.busy},   32'h1);
        tick();
        chk("w_c3_busy",  {31'b0, a.busy},   32'h0);
        chk("w_nwr",      32'(wr1 - w0),     32'd1);
        chk("w_mem",      mem1[8'h40],       32'hDEADBEEF);

        // Byte store, MEM_LAT=1
        w0 = wr1;
        a.start = 1; a.SScontroler = 2'b01; a.addr = 32'h10; a.B_out = 32'hAABBCCDD;
        tick(); a.start = 0;
        chk("b_c1_addr",  a.mem_addr,        32'h10);
        chk("b_c1_wr",    {31'b0, a.mem_wr}, 32'h0);
        tick();
        chk("b_c2_wr",    {31'b0, a.mem_wr}, 32'h0);
        tick();
        chk("b_c3_wr",    {31'b0, a.mem_wr}, 32'h1);
        chk("b_c3_data",  a.mem_wr_data,     32'h112233DD);
        tick();
        chk("b_c4_done",  {31'b0, a.done},   32'h1);
        chk("b_nwr",      32'(wr1 - w0),     32'd1);
        tick();
        chk("b_mem",      mem1[8'h10],       32'h112233DD);

        // Halfword store, MEM_LAT=3
        w0 = wr3;
        b.start = 1; b.SScontroler = 2'b10; b.addr = 32'h8; b.B_out = 32'h00001234;
        tick(); b.start = 0;
        for (int c = 1; c <= 4; c++) begin
            chk($sformatf("h_c%0d_wr", c), {31'b0, b.mem_wr}, 32'h0);
            tick();
        end
        chk("h_c5_wr",    {31'b0, b.mem_wr}, 32'h1);
        chk("h_c5_data",  b.mem_wr_data,     32'hCAFE1234);
        chk("h_c5_addr",  b.mem_addr,        32'h8);
        tick();
        chk("h_c6_done",  {31'b0, b.done},   32'h1);
        chk("h_nwr",      32'(wr3 - w0),     32'd1);
        tick();

        // Reserved size
        w0 = wr1;
        a.start = 1; a.SScontroler = 2'b11; a.addr = 32'h50; a.B_out = 32'h12121212;
        tick(); a.start = 0;
        chk("r_c1_done",  {31'b0, a.done},   32'h1);
        chk("r_c1_busy",  {31'b0, a.busy},   32'h1);
        chk("r_c1_wr",    {31'b0, a.mem_wr}, 32'h0);
        tick();
        chk("r_c2_busy",  {31'b0, a.busy},   32'h0);
        chk("r_c2_done",  {31'b0, a.done},   32'h0);
        chk("r_nwr",      32'(wr1 - w0),     32'd0);

        // Ignored start during READ / DONE, input changes mid-operation
        w0 = wr1;
        a.start = 1; a.SScontroler = 2'b10; a.addr = 32'h20; a.B_out = 32'h0000ABCD;
        tick();
        a.SScontroler = 2'b00; a.addr = 32'h30; a.B_out = 32'hFFFFFFFF;
        tick(); a.start = 0;
        tick();
        chk("i_c3_wr",    {31'b0, a.mem_wr}, 32'h1);
        chk("i_c3_addr",  a.mem_addr,        32'h20);
        chk("i_c3_data",  a.mem_wr_data,     32'h5566ABCD);
        tick();
        chk("i_c4_done",  {31'b0, a.done},   32'h1);
        a.start = 1; a.SScontroler = 2'b00; a.addr = 32'h34; a.B_out = 32'h12345678;
        tick();
        chk("i_c5_busy",  {31'b0, a.busy},   32'h0);
        tick(); a.start = 0;
        chk("i_c6_wr",    {31'b0, a.mem_wr}, 32'h1);
        chk("i_c6_addr",  a.mem_addr,        32'h34);
        chk("i_c6_data",  a.mem_wr_data,     32'h12345678);
        tick(); tick();
        chk("i_nwr",      32'(wr1 - w0),     32'd2);
        chk("i_mem30",    mem1[8'h30],       32'h0);
        chk("i_mem20",    mem1[8'h20],       32'h5566ABCD);

        // Reset in cycle 1 of a byte store
        w0 = wr1;
        a.start = 1; a.SScontroler = 2'b01; a.addr = 32'h10; a.B_out = 32'h00000099;
        tick(); a.start = 0;
        chk("x_c1_busy",  {31'b0, a.busy},   32'h1);
        reset = 1;
        tick();
        reset = 0;
        chk("x_busy",     {31'b0, a.busy},   32'h0);
        chk("x_done",     {31'b0, a.done},   32'h0);
        chk("x_wr",       {31'b0, a.mem_wr}, 32'h0);
        chk("x_addr",     a.mem_addr,        32'h0);
        chk("x_wdata",    a.mem_wr_data,     32'h0);
        tick(); tick(); tick();
        chk("x_nwr",      32'(wr1 - w0),     32'd0);
        a.start = 1; a.SScontroler = 2'b01; a.addr = 32'h10; a.B_out = 32'h00000077;
        tick(); a.start = 0;
        seen = 0;
        for (int c = 0; c < 10 && !seen; c++) begin
            if (a.done) seen = 1;
            else tick();
        end
        chk("x_after_done", {31'b0, seen},   32'h1);
        tick();
        chk("x_after_mem",  mem1[8'h10],     32'h11223377);
        chk("x_after_nwr",  32'(wr1 - w0),   32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
